// File: rtl/bcd_seg_scanner_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_seg_scanner_pkg;

  localparam int SEG_W = 7;
  localparam int DIG_W = 2;

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_seg_scanner_decode.sv
// Combinational BCD to active-high 7-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
  import bcd_seg_scanner_pkg::*;
(
  input  logic [3:0]       i_code,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Two-digit multiplexed 7-segment scanner: prescaled slot timer, DIG0/DIG1 FSM,
// frame-wide input snapshot and registered, polarity-selectable segment/anode outputs.
module bcd_seg_scanner
  import bcd_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic [3:0]       bcd0,
  input  logic [3:0]       bcd1,
  output logic [SEG_W-1:0] seg,
  output logic [DIG_W-1:0] an,
  output logic             frame_tick
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIG_W-1:0] AN_OFF   = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_snap;
  logic [SEG_W-1:0] r_seg;
  logic [DIG_W-1:0] r_an;
  logic             r_frameTick;

  logic             w_slotEnd;
  logic             w_capture;
  logic [3:0]       w_digit;
  logic [SEG_W-1:0] w_pattern;
  logic [SEG_W-1:0] w_segHigh;
  logic [DIG_W-1:0] w_anHigh;
  logic [SEG_W-1:0] w_segNext;
  logic [DIG_W-1:0] w_anNext;

  assign w_slotEnd = (r_cnt == CNT_LAST);
  assign w_capture = w_slotEnd && (r_state == DIG1);
  assign w_digit   = (r_state == DIG1) ? r_snap[7:4] : r_snap[3:0];

  bcd_to_7seg u_decode (
    .i_code (w_digit),
    .o_seg  (w_pattern)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_cnt   <= '0;
      r_state <= DIG0;
    end else begin
      r_cnt   <= w_slotEnd ? '0 : r_cnt + 1'b1;
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_slotEnd) begin
      w_nextState = (r_state == DIG0) ? DIG1 : DIG0;
    end
  end

  // Output decode works in active-high terms; polarity is applied only at the end.
  always_comb begin
    w_segHigh = w_pattern;
    w_anHigh  = '0;
    if (BLANK_LZ && (r_state == DIG1) && (r_snap[7:4] == 4'd0)) begin
      w_segHigh = SEG_BLANK;
    end
    if (!en) begin
      w_segHigh = SEG_BLANK;
    end
    if (en && (r_cnt != '0)) begin
      w_anHigh = (r_state == DIG1) ? 2'b10 : 2'b01;
    end
    w_segNext = ACTIVE_LOW ? ~w_segHigh : w_segHigh;
    w_anNext  = ACTIVE_LOW ? ~w_anHigh  : w_anHigh;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_snap      <= '0;
      r_seg       <= SEG_OFF;
      r_an        <= AN_OFF;
      r_frameTick <= 1'b0;
    end else begin
      if (w_capture) begin
        r_snap <= {bcd1, bcd0};
      end
      r_seg       <= w_segNext;
      r_an        <= w_anNext;
      r_frameTick <= w_capture;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed, table-driven bench for bcd_seg_scanner with REFRESH_DIV=4, active-low, leading-zero blanking.
module tb_bcd_seg_scanner;

  logic       clk;
  logic       rst_;
  logic       en;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] b1;
    logic [3:0] b0;
    logic [6:0] seg0;
    logic [6:0] seg1;
  } vec_t;

  vec_t vecs[6];

  bcd_seg_scanner #(
    .REFRESH_DIV (4),
    .BLANK_LZ    (1'b1),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .en         (en),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b1, input logic [3:0] b0, input logic e);
    bcd1 = b1;
    bcd0 = b0;
    en   = e;
  endtask

  // Waits (bounded) for the next frame_tick observed at a falling edge.
  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!frame_tick && cycles < 20);
    if (!frame_tick) checkOutput("tick_timeout", 0, 1);
  endtask

  function automatic logic [1:0] anExp(input int k);
    if (k == 1 || k == 5) return 2'b11;
    if (k < 5) return 2'b10;
    return 2'b01;
  endfunction

  // Checks the 8 cycles following a frame_tick.
  task automatic checkFrame(input logic [6:0] s0, input logic [6:0] s1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("seg_k%0d", k), int'(seg), int'((k <= 4) ? s0 : s1));
      checkOutput($sformatf("an_k%0d", k), int'(an), int'(anExp(k)));
      checkOutput($sformatf("tick_k%0d", k), int'(frame_tick), (k == 8) ? 1 : 0);
    end
  endtask

  initial begin
    int cyc;

    vecs[0] = '{4'd4,  4'd2,  7'h24, 7'h19};
    vecs[1] = '{4'd0,  4'd7,  7'h78, 7'h7F};
    vecs[2] = '{4'd9,  4'hC,  7'h3F, 7'h10};
    vecs[3] = '{4'd1,  4'd0,  7'h40, 7'h79};
    vecs[4] = '{4'd5,  4'd8,  7'h00, 7'h12};
    vecs[5] = '{4'hF,  4'd6,  7'h02, 7'h3F};

    rst_ = 1'b0;
    applyStimulus(4'd4, 4'd2, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset_seg", int'(seg), 'h7F);
    checkOutput("reset_an", int'(an), 'h3);
    checkOutput("reset_tick", int'(frame_tick), 0);

    rst_ = 1'b1;
    waitTick(cyc);
    checkOutput("first_tick_cycles", cyc, 8);
    checkFrame(7'h24, 7'h19);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].b1, vecs[i].b0, 1'b1);
      waitTick(cyc);
      checkFrame(vecs[i].seg0, vecs[i].seg1);
    end

    // Input change mid DIG0 slot must not tear the displayed frame.
    applyStimulus(4'd0, 4'd3, 1'b1);
    waitTick(cyc);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tear_seg_k%0d", k), int'(seg), (k <= 4) ? 'h30 : 'h7F);
      checkOutput($sformatf("tear_an_k%0d", k), int'(an), int'(anExp(k)));
      checkOutput($sformatf("tear_tick_k%0d", k), int'(frame_tick), (k == 8) ? 1 : 0);
      if (k == 2) bcd0 = 4'd8;
    end
    @(negedge clk);
    checkOutput("tear_new_seg", int'(seg), 'h00);
    checkOutput("tear_new_an", int'(an), 'h3);

    // Display enable dropped for 5 cycles.
    applyStimulus(4'd4, 4'd2, 1'b1);
    waitTick(cyc);
    waitTick(cyc);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 6) begin
        checkOutput($sformatf("en_off_seg_k%0d", k), int'(seg), 'h7F);
        checkOutput($sformatf("en_off_an_k%0d", k), int'(an), 'h3);
      end else begin
        checkOutput($sformatf("en_on_seg_k%0d", k), int'(seg), (k <= 4) ? 'h24 : 'h19);
        checkOutput($sformatf("en_on_an_k%0d", k), int'(an), int'(anExp(k)));
      end
      checkOutput($sformatf("en_tick_k%0d", k), int'(frame_tick), (k == 8) ? 1 : 0);
      if (k == 1) en = 1'b0;
      if (k == 6) en = 1'b1;
    end
    checkFrame(7'h24, 7'h19);

    // Asynchronous reset in the middle of the DIG1 slot.
    repeat (6) @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    checkOutput("async_seg", int'(seg), 'h7F);
    checkOutput("async_an", int'(an), 'h3);
    checkOutput("async_tick", int'(frame_tick), 0);
    @(negedge clk);
    rst_ = 1'b1;
    waitTick(cyc);
    checkOutput("restart_tick_cycles", cyc, 8);
    checkFrame(7'h24, 7'h19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
